// File: rtl/hq_tod_pkg.sv
// Shared HaveQuick time-of-day definitions: nibble layout, error codes and
// the assembler state encoding. The nibble source uses the same constants.
package hq_tod_pkg;

    localparam int N_NIBBLES = 12;
    localparam int N_FIELDS  = 11;

    localparam int IDX_HH_MS  = 0;
    localparam int IDX_HH_LS  = 1;
    localparam int IDX_MM_MS  = 2;
    localparam int IDX_MM_LS  = 3;
    localparam int IDX_SS_MS  = 4;
    localparam int IDX_SS_LS  = 5;
    localparam int IDX_DOY_MS = 6;
    localparam int IDX_DOY_DS = 7;
    localparam int IDX_DOY_LS = 8;
    localparam int IDX_YY_MS  = 9;
    localparam int IDX_YY_LS  = 10;
    localparam int IDX_MARKER = 11;

    localparam logic [2:0] ERR_NONE    = 3'd0;
    localparam logic [2:0] ERR_DECODE  = 3'd1;
    localparam logic [2:0] ERR_MARKER  = 3'd2;
    localparam logic [2:0] ERR_BCD     = 3'd3;
    localparam logic [2:0] ERR_RANGE   = 3'd4;
    localparam logic [2:0] ERR_TIMEOUT = 3'd5;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_COLLECT,
        ST_CHECK,
        ST_PUBLISH
    } tod_state_e;

    // Widths leave headroom so illegal BCD digits cannot wrap into a legal value.
    function automatic logic [7:0] bcd2_value(input logic [3:0] ms, input logic [3:0] ls);
        return 8'(ms) * 8'd10 + 8'(ls);
    endfunction

    function automatic logic [10:0] bcd3_value(input logic [3:0] hs, input logic [3:0] ds,
                                               input logic [3:0] ls);
        return 11'(hs) * 11'd100 + 11'(ds) * 11'd10 + 11'(ls);
    endfunction

endpackage

// File: rtl/tod_range_check.sv
// Combinational legality check of one collected frame: marker value, BCD
// digit legality and calendar/clock field ranges.
module tod_range_check
    import hq_tod_pkg::*;
#(
    parameter logic [3:0] MARKER = 4'd1
) (
    input  logic [4*N_NIBBLES-1:0] nibbles,
    output logic                   bcd_fail,
    output logic                   range_fail,
    output logic                   marker_fail
);

    logic [7:0]  hh;
    logic [7:0]  mm;
    logic [7:0]  ss;
    logic [10:0] doy;

    // Leap years are not distinguished; day 366 is always accepted.
    always_comb begin
        bcd_fail = 1'b0;
        for (int i = 0; i < N_FIELDS; i++) begin
            if (nibbles[4*i +: 4] > 4'd9) begin
                bcd_fail = 1'b1;
            end
        end
        hh  = bcd2_value(nibbles[4*IDX_HH_MS +: 4], nibbles[4*IDX_HH_LS +: 4]);
        mm  = bcd2_value(nibbles[4*IDX_MM_MS +: 4], nibbles[4*IDX_MM_LS +: 4]);
        ss  = bcd2_value(nibbles[4*IDX_SS_MS +: 4], nibbles[4*IDX_SS_LS +: 4]);
        doy = bcd3_value(nibbles[4*IDX_DOY_MS +: 4], nibbles[4*IDX_DOY_DS +: 4],
                         nibbles[4*IDX_DOY_LS +: 4]);
        range_fail  = (hh > 8'd23) | (mm > 8'd59) | (ss > 8'd59) |
                      (doy == 11'd0) | (doy > 11'd366);
        marker_fail = (nibbles[4*IDX_MARKER +: 4] != MARKER);
    end

endmodule

// File: rtl/bcd_tod_assembler.sv
// Reassembles decoded HaveQuick nibbles into a checked time-of-day word and
// publishes it with a one-cycle time_valid, or rejects it with an error code.
module bcd_tod_assembler
    import hq_tod_pkg::*;
#(
    parameter int         TIMEOUT_CYCLES = 1024,
    parameter logic [3:0] MARKER         = 4'd1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       sync,
    input  logic [3:0] in_data,
    input  logic       in_valid,
    input  logic       in_err,
    output logic       ready,
    output logic [3:0] hh_ms,
    output logic [3:0] hh_ls,
    output logic [3:0] mm_ms,
    output logic [3:0] mm_ls,
    output logic [3:0] ss_ms,
    output logic [3:0] ss_ls,
    output logic [3:0] doy_ms,
    output logic [3:0] doy_ds,
    output logic [3:0] doy_ls,
    output logic [3:0] yy_ms,
    output logic [3:0] yy_ls,
    output logic       time_valid,
    output logic       frame_err,
    output logic [2:0] err_code,
    output logic       busy
);

    localparam int            TW         = $clog2(TIMEOUT_CYCLES);
    localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT_CYCLES - 1);

    tod_state_e    state_q, state_d;
    logic [3:0]    idx_q, idx_d;
    logic          derr_q, derr_d;
    logic [TW-1:0] timer_q, timer_d;
    logic [3:0]    nib_q [N_NIBBLES];
    logic [3:0]    nib_d [N_NIBBLES];
    logic [3:0]    fld_q [N_FIELDS];
    logic [3:0]    fld_d [N_FIELDS];
    logic          ready_q, ready_d;
    logic          time_valid_q, time_valid_d;
    logic          frame_err_q, frame_err_d;
    logic [2:0]    err_code_q, err_code_d;
    logic          busy_q, busy_d;

    logic                   accept;
    logic [4*N_NIBBLES-1:0] nib_flat;
    logic                   bcd_fail;
    logic                   range_fail;
    logic                   marker_fail;
    logic [2:0]             check_code;

    assign accept = in_valid & ready_q;

    always_comb begin
        nib_flat = '0;
        for (int i = 0; i < N_NIBBLES; i++) begin
            nib_flat[4*i +: 4] = nib_q[i];
        end
    end

    tod_range_check #(
        .MARKER(MARKER)
    ) u_range_check (
        .nibbles    (nib_flat),
        .bcd_fail   (bcd_fail),
        .range_fail (range_fail),
        .marker_fail(marker_fail)
    );

    // Lowest error code wins when several faults coincide.
    always_comb begin
        check_code = ERR_NONE;
        if (derr_q) begin
            check_code = ERR_DECODE;
        end else if (marker_fail) begin
            check_code = ERR_MARKER;
        end else if (bcd_fail) begin
            check_code = ERR_BCD;
        end else if (range_fail) begin
            check_code = ERR_RANGE;
        end
    end

    always_comb begin
        state_d      = state_q;
        idx_d        = idx_q;
        derr_d       = derr_q;
        timer_d      = timer_q;
        nib_d        = nib_q;
        fld_d        = fld_q;
        time_valid_d = 1'b0;
        frame_err_d  = 1'b0;
        err_code_d   = ERR_NONE;

        case (state_q)
            ST_IDLE: begin
                derr_d  = 1'b0;
                timer_d = '0;
                if (accept) begin
                    nib_d[0] = in_data;
                    derr_d   = in_err;
                    idx_d    = 4'd1;
                    state_d  = ST_COLLECT;
                end
            end
            ST_COLLECT: begin
                if (accept) begin
                    nib_d[idx_q] = in_data;
                    derr_d       = derr_q | in_err;
                    timer_d      = '0;
                    if (idx_q == 4'(IDX_MARKER)) begin
                        state_d = ST_CHECK;
                    end else begin
                        idx_d = idx_q + 4'd1;
                    end
                end else if (timer_q == TIMER_LAST) begin
                    frame_err_d = 1'b1;
                    err_code_d  = ERR_TIMEOUT;
                    idx_d       = 4'd0;
                    derr_d      = 1'b0;
                    timer_d     = '0;
                    state_d     = ST_IDLE;
                end else begin
                    timer_d = timer_q + TW'(1);
                end
            end
            ST_CHECK: begin
                idx_d   = 4'd0;
                state_d = ST_PUBLISH;
                if (check_code != ERR_NONE) begin
                    frame_err_d = 1'b1;
                    err_code_d  = check_code;
                end else begin
                    time_valid_d = 1'b1;
                    for (int i = 0; i < N_FIELDS; i++) begin
                        fld_d[i] = nib_q[i];
                    end
                end
            end
            ST_PUBLISH: begin
                derr_d  = 1'b0;
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // sync wins over everything: a nibble arriving with it is dropped.
        if (sync) begin
            state_d      = ST_IDLE;
            idx_d        = 4'd0;
            derr_d       = 1'b0;
            timer_d      = '0;
            nib_d        = nib_q;
            fld_d        = fld_q;
            time_valid_d = 1'b0;
            frame_err_d  = 1'b0;
            err_code_d   = ERR_NONE;
        end

        ready_d = (state_d == ST_IDLE) || (state_d == ST_COLLECT);
        busy_d  = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            idx_q        <= 4'd0;
            derr_q       <= 1'b0;
            timer_q      <= '0;
            ready_q      <= 1'b0;
            time_valid_q <= 1'b0;
            frame_err_q  <= 1'b0;
            err_code_q   <= ERR_NONE;
            busy_q       <= 1'b0;
            for (int i = 0; i < N_NIBBLES; i++) begin
                nib_q[i] <= 4'd0;
            end
            for (int i = 0; i < N_FIELDS; i++) begin
                fld_q[i] <= 4'd0;
            end
        end else begin
            state_q      <= state_d;
            idx_q        <= idx_d;
            derr_q       <= derr_d;
            timer_q      <= timer_d;
            ready_q      <= ready_d;
            time_valid_q <= time_valid_d;
            frame_err_q  <= frame_err_d;
            err_code_q   <= err_code_d;
            busy_q       <= busy_d;
            nib_q        <= nib_d;
            fld_q        <= fld_d;
        end
    end

    assign ready      = ready_q;
    assign time_valid = time_valid_q;
    assign frame_err  = frame_err_q;
    assign err_code   = err_code_q;
    assign busy       = busy_q;
    assign hh_ms      = fld_q[IDX_HH_MS];
    assign hh_ls      = fld_q[IDX_HH_LS];
    assign mm_ms      = fld_q[IDX_MM_MS];
    assign mm_ls      = fld_q[IDX_MM_LS];
    assign ss_ms      = fld_q[IDX_SS_MS];
    assign ss_ls      = fld_q[IDX_SS_LS];
    assign doy_ms     = fld_q[IDX_DOY_MS];
    assign doy_ds     = fld_q[IDX_DOY_DS];
    assign doy_ls     = fld_q[IDX_DOY_LS];
    assign yy_ms      = fld_q[IDX_YY_MS];
    assign yy_ls      = fld_q[IDX_YY_LS];

endmodule

// File: tb/tb_bcd_tod_assembler.sv
// Self-checking bench for bcd_tod_assembler: directed frames from the test
// plan plus randomized frames checked against a plain-arithmetic frame model.
module tb_bcd_tod_assembler;

    localparam int TIMEOUT = 1024;

    logic       clk = 1'b0;
    logic       rst, sync, in_valid, in_err;
    logic [3:0] in_data;
    logic       ready, time_valid, frame_err, busy;
    logic [2:0] err_code;
    logic [3:0] hh_ms, hh_ls, mm_ms, mm_ls, ss_ms, ss_ls;
    logic [3:0] doy_ms, doy_ds, doy_ls, yy_ms, yy_ls;
    logic [43:0] dut_fields;

    int n_cmp = 0;
    int n_fail = 0;
    int tv_count = 0;

    logic [3:0] fr_nib [12];
    logic       fr_errs [12];
    logic [3:0] exp_fld [11];

    logic       obs_early, obs_tv, obs_fe, obs_ready, obs_busy;
    logic [2:0] obs_code;
    logic [43:0] obs_fields;

    bcd_tod_assembler #(.TIMEOUT_CYCLES(TIMEOUT), .MARKER(4'd1)) dut (
        .clk(clk), .rst(rst), .sync(sync), .in_data(in_data), .in_valid(in_valid),
        .in_err(in_err), .ready(ready),
        .hh_ms(hh_ms), .hh_ls(hh_ls), .mm_ms(mm_ms), .mm_ls(mm_ls),
        .ss_ms(ss_ms), .ss_ls(ss_ls), .doy_ms(doy_ms), .doy_ds(doy_ds),
        .doy_ls(doy_ls), .yy_ms(yy_ms), .yy_ls(yy_ls),
        .time_valid(time_valid), .frame_err(frame_err), .err_code(err_code), .busy(busy)
    );

    always #5 clk = ~clk;

    assign dut_fields = {hh_ms, hh_ls, mm_ms, mm_ls, ss_ms, ss_ls,
                         doy_ms, doy_ds, doy_ls, yy_ms, yy_ls};

    always @(negedge clk) begin
        if (time_valid === 1'b1) tv_count++;
    end

    // Reference model: the frame's verdict from its decimal meaning.
    function automatic logic [2:0] model_code();
        int hh, mm, ss, doy;
        for (int i = 0; i < 12; i++) if (fr_errs[i]) return 3'd1;
        if (fr_nib[11] != 4'd1) return 3'd2;
        for (int i = 0; i < 11; i++) if (fr_nib[i] > 4'd9) return 3'd3;
        hh  = int'(fr_nib[0]) * 10 + int'(fr_nib[1]);
        mm  = int'(fr_nib[2]) * 10 + int'(fr_nib[3]);
        ss  = int'(fr_nib[4]) * 10 + int'(fr_nib[5]);
        doy = int'(fr_nib[6]) * 100 + int'(fr_nib[7]) * 10 + int'(fr_nib[8]);
        if (hh > 23 || mm > 59 || ss > 59 || doy == 0 || doy > 366) return 3'd4;
        return 3'd0;
    endfunction

    function automatic void commit_fields();
        for (int i = 0; i < 11; i++) exp_fld[i] = fr_nib[i];
    endfunction

    function automatic logic [43:0] exp_pack();
        logic [43:0] v = '0;
        for (int i = 0; i < 11; i++) v = {v[39:0], exp_fld[i]};
        return v;
    endfunction

    task automatic set_base();
        int base [12] = '{1, 2, 3, 4, 5, 6, 3, 6, 5, 2, 5, 1};
        for (int i = 0; i < 12; i++) begin
            fr_nib[i]  = 4'(base[i]);
            fr_errs[i] = 1'b0;
        end
    endtask

    task automatic gen_frame(input int mode);
        int hh, mm, ss, doy, yy;
        hh = $urandom_range(0, 23); mm = $urandom_range(0, 59); ss = $urandom_range(0, 59);
        doy = $urandom_range(1, 366); yy = $urandom_range(0, 99);
        fr_nib[0] = 4'(hh / 10);   fr_nib[1] = 4'(hh % 10);
        fr_nib[2] = 4'(mm / 10);   fr_nib[3] = 4'(mm % 10);
        fr_nib[4] = 4'(ss / 10);   fr_nib[5] = 4'(ss % 10);
        fr_nib[6] = 4'(doy / 100); fr_nib[7] = 4'((doy / 10) % 10); fr_nib[8] = 4'(doy % 10);
        fr_nib[9] = 4'(yy / 10);   fr_nib[10] = 4'(yy % 10);
        fr_nib[11] = 4'd1;
        for (int i = 0; i < 12; i++) fr_errs[i] = 1'b0;
        case (mode)
            1: fr_errs[$urandom_range(0, 11)] = 1'b1;
            2: fr_nib[11] = 4'($urandom_range(2, 16));
            3: fr_nib[$urandom_range(0, 10)] = 4'($urandom_range(10, 15));
            4: case ($urandom_range(0, 3))
                   0: begin fr_nib[0] = 4'd2; fr_nib[1] = 4'($urandom_range(4, 9)); end
                   1: fr_nib[2] = 4'($urandom_range(6, 9));
                   2: fr_nib[4] = 4'($urandom_range(6, 9));
                   default: begin fr_nib[6] = 4'd3; fr_nib[7] = 4'd6; fr_nib[8] = 4'($urandom_range(7, 9)); end
               endcase
            5: for (int i = 0; i < 12; i++) begin
                   fr_nib[i]  = (i == 11 && $urandom_range(0, 1) == 1) ? 4'd1 : 4'($urandom_range(0, 15));
                   fr_errs[i] = ($urandom_range(0, 7) == 0);
               end
            default: ;
        endcase
    endtask

    // Present one nibble (after an idle gap) and hold it until ready takes it.
    task automatic drive_nibble(input logic [3:0] d, input logic e, input int gap);
        in_valid = 1'b0;
        in_err   = 1'b0;
        repeat (gap) @(negedge clk);
        in_valid = 1'b1;
        in_data  = d;
        in_err   = e;
        for (int w = 0; w < 20; w++) begin
            if (ready === 1'b1) begin
                @(negedge clk);
                in_valid = 1'b0;
                in_err   = 1'b0;
                return;
            end
            @(negedge clk);
        end
        n_cmp++;
        n_fail++;
        $display("[TB] FAIL accept_wait: ready=%b after 20 cycles, required 1", ready);
        in_valid = 1'b0;
        in_err   = 1'b0;
    endtask

    // Drive the current frame and capture what the DUT shows in T+1..T+3.
    task automatic run_frame(input int max_gap);
        for (int i = 0; i < 12; i++) begin
            drive_nibble(fr_nib[i], fr_errs[i], (max_gap > 0) ? $urandom_range(0, max_gap) : 0);
        end
        obs_early = time_valid | frame_err;
        @(negedge clk);
        obs_tv   = time_valid;
        obs_fe   = frame_err;
        obs_code = err_code;
        @(negedge clk);
        obs_fields = dut_fields;
        obs_ready  = ready;
        obs_busy   = busy;
    endtask

    task automatic test_reset();
        rst = 1'b1; sync = 1'b0; in_valid = 1'b0; in_err = 1'b0; in_data = 4'd0;
        for (int i = 0; i < 11; i++) exp_fld[i] = 4'd0;
        repeat (3) @(negedge clk);
        n_cmp++; if (ready !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_ready: got %b want 0", ready); end
        n_cmp++; if ({time_valid, frame_err, busy} !== 3'b000) begin n_fail++; $display("[TB] FAIL reset_pulses: got %b want 000", {time_valid, frame_err, busy}); end
        n_cmp++; if (err_code !== 3'd0) begin n_fail++; $display("[TB] FAIL reset_code: got %0d want 0", err_code); end
        n_cmp++; if (dut_fields !== 44'd0) begin n_fail++; $display("[TB] FAIL reset_fields: got %h want 0", dut_fields); end
        rst = 1'b0;
        @(negedge clk);
        n_cmp++; if (ready !== 1'b1) begin n_fail++; $display("[TB] FAIL reset_release_ready: got %b want 1", ready); end
    endtask

    task automatic test_error_table();
        logic [2:0] want [6] = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd4};
        for (int s = 0; s < 6; s++) begin
            set_base();
            case (s)
                1: begin fr_nib[0] = 4'd2; fr_nib[1] = 4'd5; fr_errs[4] = 1'b1; end
                2: fr_nib[11] = 4'd0;
                3: fr_nib[3] = 4'hA;
                4: begin fr_nib[6] = 4'd3; fr_nib[7] = 4'd6; fr_nib[8] = 4'd7; end
                5: begin fr_nib[6] = 4'd0; fr_nib[7] = 4'd0; fr_nib[8] = 4'd0; end
                default: ;
            endcase
            run_frame(0);
            if (want[s] == 3'd0) commit_fields();
            n_cmp++; if (obs_early !== 1'b0) begin n_fail++; $display("[TB] FAIL table%0d early_pulse: got %b want 0", s, obs_early); end
            n_cmp++; if (obs_tv !== (want[s] == 3'd0)) begin n_fail++; $display("[TB] FAIL table%0d time_valid: got %b want %b", s, obs_tv, want[s] == 3'd0); end
            n_cmp++; if (obs_fe !== (want[s] != 3'd0)) begin n_fail++; $display("[TB] FAIL table%0d frame_err: got %b want %b", s, obs_fe, want[s] != 3'd0); end
            n_cmp++; if (obs_code !== want[s]) begin n_fail++; $display("[TB] FAIL table%0d err_code: got %0d want %0d", s, obs_code, want[s]); end
            n_cmp++; if (obs_fields !== exp_pack()) begin n_fail++; $display("[TB] FAIL table%0d fields: got %h want %h", s, obs_fields, exp_pack()); end
            n_cmp++; if (obs_ready !== 1'b1) begin n_fail++; $display("[TB] FAIL table%0d ready_after: got %b want 1", s, obs_ready); end
        end
    endtask

    task automatic test_timeout();
        int  waited = -1;
        logic saw_tv = 1'b0;
        logic [2:0] code_seen = 3'd0;
        gen_frame(0);
        for (int i = 0; i < 5; i++) drive_nibble(fr_nib[i], 1'b0, 0);
        for (int w = 0; w < TIMEOUT + 100; w++) begin
            if (time_valid === 1'b1) saw_tv = 1'b1;
            if (frame_err === 1'b1) begin waited = w; code_seen = err_code; break; end
            @(negedge clk);
        end
        n_cmp++; if (waited < TIMEOUT - 2 || waited > TIMEOUT + 4) begin n_fail++; $display("[TB] FAIL timeout_latency: got %0d cycles want about %0d", waited, TIMEOUT); end
        n_cmp++; if (code_seen !== 3'd5) begin n_fail++; $display("[TB] FAIL timeout_code: got %0d want 5", code_seen); end
        n_cmp++; if (saw_tv !== 1'b0) begin n_fail++; $display("[TB] FAIL timeout_no_tv: got %b want 0", saw_tv); end
        @(negedge clk);
        n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("[TB] FAIL timeout_busy: got %b want 0", busy); end
        n_cmp++; if (dut_fields !== exp_pack()) begin n_fail++; $display("[TB] FAIL timeout_fields_held: got %h want %h", dut_fields, exp_pack()); end
        gen_frame(0);
        run_frame(0);
        commit_fields();
        n_cmp++; if (obs_tv !== 1'b1) begin n_fail++; $display("[TB] FAIL timeout_next_tv: got %b want 1", obs_tv); end
        n_cmp++; if (obs_fields !== exp_pack()) begin n_fail++; $display("[TB] FAIL timeout_next_fields: got %h want %h", obs_fields, exp_pack()); end
    endtask

    task automatic test_sync_abort();
        int tv_before;
        gen_frame(0);
        for (int i = 0; i < 7; i++) drive_nibble(fr_nib[i], 1'b0, 0);
        sync = 1'b1;
        @(negedge clk);
        sync = 1'b0;
        n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("[TB] FAIL sync_busy: got %b want 0", busy); end
        @(posedge clk);
        tv_before = tv_count;
        @(negedge clk);
        gen_frame(0);
        run_frame(0);
        commit_fields();
        n_cmp++; if (obs_tv !== 1'b1) begin n_fail++; $display("[TB] FAIL sync_second_tv: got %b want 1", obs_tv); end
        n_cmp++; if (obs_fields !== exp_pack()) begin n_fail++; $display("[TB] FAIL sync_second_fields: got %h want %h", obs_fields, exp_pack()); end
        @(posedge clk);
        n_cmp++; if (tv_count - tv_before !== 1) begin n_fail++; $display("[TB] FAIL sync_tv_count: got %0d want 1", tv_count - tv_before); end
        @(negedge clk);
    endtask

    task automatic test_sync_coincident();
        drive_nibble(4'($urandom_range(0, 15)), 1'b0, 0);
        drive_nibble(4'($urandom_range(0, 15)), 1'b0, 0);
        sync     = 1'b1;
        in_valid = 1'b1;
        in_data  = 4'($urandom_range(0, 9));
        @(negedge clk);
        sync     = 1'b0;
        in_valid = 1'b0;
        gen_frame(0);
        run_frame(0);
        commit_fields();
        n_cmp++; if (obs_tv !== 1'b1 || obs_fe !== 1'b0) begin n_fail++; $display("[TB] FAIL sync_coincident_pulse: got tv=%b fe=%b want tv=1 fe=0", obs_tv, obs_fe); end
        n_cmp++; if (obs_fields !== exp_pack()) begin n_fail++; $display("[TB] FAIL sync_coincident_fields: got %h want %h", obs_fields, exp_pack()); end
    endtask

    task automatic test_rst_in_check();
        gen_frame(0);
        for (int i = 0; i < 12; i++) drive_nibble(fr_nib[i], 1'b0, 0);
        rst = 1'b1;
        for (int i = 0; i < 11; i++) exp_fld[i] = 4'd0;
        @(negedge clk);
        n_cmp++; if ({time_valid, frame_err, ready, busy} !== 4'b0000) begin n_fail++; $display("[TB] FAIL rst_check_outputs: got %b want 0000", {time_valid, frame_err, ready, busy}); end
        n_cmp++; if (dut_fields !== exp_pack() || err_code !== 3'd0) begin n_fail++; $display("[TB] FAIL rst_check_fields: got %h/%0d want 0/0", dut_fields, err_code); end
        rst = 1'b0;
        @(negedge clk);
        n_cmp++; if (ready !== 1'b1) begin n_fail++; $display("[TB] FAIL rst_check_ready: got %b want 1", ready); end
        n_cmp++; if (time_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL rst_check_no_tv: got %b want 0", time_valid); end
    endtask

    task automatic test_back_to_back(input int n, input int max_gap);
        logic [2:0] exp_code;
        int mode;
        for (int f = 0; f < n; f++) begin
            mode = $urandom_range(0, 9);
            gen_frame(mode > 5 ? 0 : mode);
            run_frame(max_gap);
            exp_code = model_code();
            if (exp_code == 3'd0) commit_fields();
            n_cmp++; if (obs_early !== 1'b0) begin n_fail++; $display("[TB] FAIL rnd%0d_g%0d early_pulse: got %b want 0", f, max_gap, obs_early); end
            n_cmp++; if (obs_tv !== (exp_code == 3'd0) || obs_fe !== (exp_code != 3'd0)) begin n_fail++; $display("[TB] FAIL rnd%0d_g%0d pulses: got tv=%b fe=%b want code %0d", f, max_gap, obs_tv, obs_fe, exp_code); end
            if (exp_code != 3'd0) begin
                n_cmp++; if (obs_code !== exp_code) begin n_fail++; $display("[TB] FAIL rnd%0d_g%0d err_code: got %0d want %0d", f, max_gap, obs_code, exp_code); end
            end
            n_cmp++; if (obs_fields !== exp_pack()) begin n_fail++; $display("[TB] FAIL rnd%0d_g%0d fields: got %h want %h", f, max_gap, obs_fields, exp_pack()); end
            n_cmp++; if (obs_ready !== 1'b1 || obs_busy !== 1'b0) begin n_fail++; $display("[TB] FAIL rnd%0d_g%0d idle_after: got ready=%b busy=%b want 1/0", f, max_gap, obs_ready, obs_busy); end
        end
    endtask

    initial begin
        test_reset();
        test_error_table();
        test_timeout();
        test_sync_abort();
        test_sync_coincident();
        test_rst_in_check();
        test_back_to_back(20, 0);
        test_back_to_back(20, 3);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #1000000;
        n_fail++;
        $display("[TB] FAIL watchdog: simulation still running at %0t, required completion", $time);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
